// File: rtl/axi_lite_user_regfile.sv
// Register file with burst-capable user bus (AW/W/B, AR/R) and a hardware-side write port.
// Read and write engines run independently; bus writes win over hw writes to the same index.
module axi_lite_user_regfile #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 16
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic                                     awvalid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            awaddr,
    input  logic [7:0]                               awlen,
    output logic                                     awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            wdata,
    input  logic                                     wlast,
    input  logic                                     wvalid,
    output logic                                     wready,
    output logic                                     bvalid,
    input  logic                                     bready,
    input  logic                                     arvalid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            araddr,
    input  logic [7:0]                               arlen,
    output logic                                     arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            rdata,
    output logic                                     rlast,
    output logic                                     rvalid,
    input  logic                                     rready,
    input  logic                                     hw_wen,
    input  logic [$clog2(NUM_REGS)-1:0]              hw_windex,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            hw_wdata,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic                                     wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]              wr_index
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int IW       = $clog2(NUM_REGS);
    localparam int ADDR_LSB = $clog2(DW / 8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t      w_state;
    r_state_t      r_state;
    logic [IW-1:0] w_index;
    logic [IW-1:0] r_index;
    logic [7:0]    w_count;
    logic [7:0]    r_count;
    logic [DW-1:0] regs [NUM_REGS];

    logic          bus_we;
    logic          hw_we;
    logic [IW-1:0] aw_index;
    logic [IW-1:0] ar_index;
    logic [IW-1:0] r_next;
    logic          unused;

    assign aw_index = awaddr[ADDR_LSB +: IW];
    assign ar_index = araddr[ADDR_LSB +: IW];
    assign r_next   = r_index + IW'(1);
    assign bus_we   = (w_state == W_DATA) && wvalid && wready;
    assign hw_we    = hw_wen && !(bus_we && (hw_windex == w_index));
    // Upper address bits alias by design; wlast is not needed since awlen drives the beat count.
    assign unused   = ^{wlast, awaddr, araddr};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (hw_we) begin
                regs[hw_windex] <= hw_wdata;
            end
            if (bus_we) begin
                regs[w_index] <= wdata;
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DW +: DW] = regs[i];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            wr_pulse <= 1'b0;
            wr_index <= '0;
            w_index  <= '0;
            w_count  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_index <= aw_index;
                        w_count <= awlen;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        wr_pulse <= 1'b1;
                        wr_index <= w_index;
                        w_index  <= w_index + IW'(1);
                        if (w_count == 8'd0) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_count <= w_count - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata samples the array before this edge's writes land, giving pre-write values on collisions.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            r_index <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_index <= ar_index;
                        rdata   <= regs[ar_index];
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_count <= arlen;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_index <= r_next;
                            rdata   <= regs[r_next];
                            rlast   <= (r_count == 8'd1);
                            r_count <= r_count - 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_user_regfile.sv
// Directed bench for axi_lite_user_regfile: transaction-level register model, per-cycle
// comparison of reg_out / wr_pulse / wr_index, and literal expectations from hand computation.
module tb_axi_lite_user_regfile;
    localparam int TMO = 20;

    logic        ACLK;
    logic        ARESET;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        hw_wen;
    logic [3:0]  hw_windex;
    logic [31:0] hw_wdata;
    logic [511:0] reg_out;
    logic        wr_pulse;
    logic [3:0]  wr_index;

    axi_lite_user_regfile #(
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .hw_wen(hw_wen), .hw_windex(hw_windex), .hw_wdata(hw_wdata),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .wr_index(wr_index)
    );

    typedef struct {
        int         cyc;
        logic [3:0] idx;
    } pulse_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] model [16];
    pulse_t      pq [$];
    logic [31:0] rd_got [16];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    // Model-vs-DUT comparison on every cycle.
    initial begin
        logic exp_p;
        forever begin
            @(negedge ACLK);
            for (int i = 0; i < 16; i++) begin
                check($sformatf("reg_out[%0d]", i), reg_of(i), model[4'(i)]);
            end
            while (pq.size() > 0 && pq[0].cyc < cyc) void'(pq.pop_front());
            exp_p = (pq.size() > 0 && pq[0].cyc == cyc);
            check("wr_pulse", 32'(wr_pulse), 32'(exp_p));
            if (exp_p) begin
                check("wr_index", 32'(wr_index), 32'(pq[0].idx));
                void'(pq.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"},  32'(wready),  32'd0);
        check({tag, "_bvalid"},  32'(bvalid),  32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_rvalid"},  32'(rvalid),  32'd0);
        check({tag, "_rlast"},   32'(rlast),   32'd0);
        check({tag, "_rdata"},   rdata,        32'd0);
        check({tag, "_wr_pulse"}, 32'(wr_pulse), 32'd0);
    endtask

    task automatic bus_write(input logic [31:0] addr, input int unsigned len, input logic [31:0] base,
                             input logic hw_en, input logic [3:0] hw_idx, input logic [31:0] hw_dat,
                             input int unsigned b_delay);
        logic [3:0]  idx;
        int unsigned n;
        idx = addr[5:2];
        awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!awready && n < TMO);
        check("aw_ready", 32'(awready), 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0;
        for (int unsigned b = 0; b <= len; b++) begin
            wdata = base + 32'(b); wlast = (b == len); wvalid = 1'b1;
            if (b == 0 && hw_en) begin
                hw_wen = 1'b1; hw_windex = hw_idx; hw_wdata = hw_dat;
            end
            n = 0;
            do begin @(negedge ACLK); n++; end while (!wready && n < TMO);
            check("w_ready", 32'(wready), 32'd1);
            @(posedge ACLK); #1;
            if (hw_wen && hw_windex != idx) model[hw_windex] = hw_wdata;
            model[idx] = wdata;
            pq.push_back('{cyc: cyc, idx: idx});
            hw_wen = 1'b0; wvalid = 1'b0; wlast = 1'b0;
            idx = idx + 4'd1;
        end
        for (int unsigned k = 0; k < b_delay; k++) begin
            @(negedge ACLK);
            check("b_hold", 32'(bvalid), 32'd1);
            @(posedge ACLK); #1;
        end
        bready = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bvalid && n < TMO);
        check("b_valid", 32'(bvalid), 32'd1);
        @(posedge ACLK); #1;
        bready = 1'b0;
        @(negedge ACLK);
        check("b_done", 32'(bvalid), 32'd0);
        check("aw_idle", 32'(awready), 32'd1);
        @(posedge ACLK); #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, input int unsigned len,
                            input int unsigned stall_beat, input int unsigned stall_len);
        logic [3:0]  idx;
        logic [31:0] exp_d;
        int unsigned n;
        idx = addr[5:2];
        araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!arready && n < TMO);
        check("ar_ready", 32'(arready), 32'd1);
        @(posedge ACLK);
        exp_d = model[idx];
        #1;
        arvalid = 1'b0;
        for (int unsigned b = 0; b <= len; b++) begin
            if (b == stall_beat && stall_len > 0) begin
                rready = 1'b0;
                for (int unsigned k = 0; k < stall_len; k++) begin
                    @(negedge ACLK);
                    check("stall_rvalid", 32'(rvalid), 32'd1);
                    check("stall_rdata", rdata, exp_d);
                    check("stall_rlast", 32'(rlast), 32'(b == len));
                    @(posedge ACLK); #1;
                end
            end
            rready = 1'b1;
            @(negedge ACLK);
            check("rvalid", 32'(rvalid), 32'd1);
            check("rdata", rdata, exp_d);
            check("rlast", 32'(rlast), 32'(b == len));
            rd_got[b] = rdata;
            @(posedge ACLK);
            idx = idx + 4'd1;
            exp_d = model[idx];
            #1;
        end
        rready = 1'b0;
        @(negedge ACLK);
        check("r_done_rvalid", 32'(rvalid), 32'd0);
        check("r_done_arready", 32'(arready), 32'd1);
        @(posedge ACLK); #1;
    endtask

    task automatic hw_write(input logic [3:0] idx, input logic [31:0] dat);
        hw_wen = 1'b1; hw_windex = idx; hw_wdata = dat;
        @(posedge ACLK); #1;
        hw_wen = 1'b0;
        model[idx] = dat;
    endtask

    initial begin
        int unsigned n;
        for (int i = 0; i < 16; i++) model[i] = '0;
        ARESET = 1'b1;
        awvalid = 0; awaddr = '0; awlen = '0; wdata = '0; wlast = 0; wvalid = 0; bready = 0;
        arvalid = 0; araddr = '0; arlen = '0; rready = 0; hw_wen = 0; hw_windex = '0; hw_wdata = '0;

        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("in_reset");
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("pre_edge_awready", 32'(awready), 32'd0);
        @(negedge ACLK);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);
        @(posedge ACLK); #1;

        // Single write with 3 cycles of B backpressure.
        bus_write(32'h08, 0, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 3);
        check("single_write_reg2", reg_of(2), 32'hDEADBEEF);

        // Wrapping burst write then wrapping burst reads.
        bus_write(32'h38, 3, 32'h100, 1'b0, 4'd0, 32'd0, 0);
        check("wrap_write_reg0", reg_of(0), 32'h102);
        bus_read(32'h38, 3, 99, 0);
        check("burst_rd0", rd_got[0], 32'h100);
        check("burst_rd1", rd_got[1], 32'h101);
        check("burst_rd2", rd_got[2], 32'h102);
        check("burst_rd3", rd_got[3], 32'h103);
        bus_read(32'h38, 3, 1, 5);
        check("bp_rd0", rd_got[0], 32'h100);
        check("bp_rd1", rd_got[1], 32'h101);
        check("bp_rd2", rd_got[2], 32'h102);
        check("bp_rd3", rd_got[3], 32'h103);

        // Collisions between bus and hw writes.
        bus_write(32'h14, 0, 32'h1, 1'b1, 4'd5, 32'h2, 0);
        check("collide_reg5", reg_of(5), 32'h1);
        bus_write(32'h18, 0, 32'h1, 1'b1, 4'd7, 32'h2, 0);
        check("split_reg6", reg_of(6), 32'h1);
        check("split_reg7", reg_of(7), 32'h2);

        // Read loading index 3 on the same edge as a bus write to index 3.
        hw_write(4'd3, 32'h33);
        fork
            bus_write(32'h0C, 0, 32'hAA, 1'b0, 4'd0, 32'd0, 0);
            begin
                @(posedge ACLK); #1;
                bus_read(32'h0C, 0, 99, 0);
            end
        join
        check("concurrent_old", rd_got[0], 32'h33);
        bus_read(32'h0C, 0, 99, 0);
        check("later_new", rd_got[0], 32'hAA);

        // Address aliasing: only addr[5:2] selects the register.
        bus_read(32'h1000_0048, 0, 99, 0);
        check("alias_read", rd_got[0], 32'hDEADBEEF);

        // Reset after 2 beats of a 4-beat write.
        awaddr = 32'h20; awlen = 8'd3; awvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!awready && n < TMO);
        check("rst_aw_ready", 32'(awready), 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 32'h500 + 32'(b); wvalid = 1'b1;
            n = 0;
            do begin @(negedge ACLK); n++; end while (!wready && n < TMO);
            check("rst_w_ready", 32'(wready), 32'd1);
            @(posedge ACLK); #1;
            model[4'(8 + b)] = wdata;
            pq.push_back('{cyc: cyc, idx: 4'(8 + b)});
        end
        ARESET = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        pq.delete();
        bready = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            check_all_zero("mid_reset");
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check("rel_awready", 32'(awready), 32'd1);
        repeat (4) begin
            @(negedge ACLK);
            check("rel_no_bvalid", 32'(bvalid), 32'd0);
            check("rel_no_wready", 32'(wready), 32'd0);
        end
        @(posedge ACLK); #1;
        wvalid = 1'b0; bready = 1'b0;
        @(negedge ACLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
